// File: rtl/srt_div_sched.sv
// srt_div_sched: round-robin scheduler that shares one fully pipelined 8-bit
// radix-4 SRT divider among NREQ requesters. Each issued operation carries a
// tag down a shift register matched to the divider latency, so its result can
// be steered into the originating requester's result FIFO. Per-requester
// credits (in flight + buffered) bound every FIFO, so a FIFO can never overflow.
// Optional feature: define SRT_SCHED_DZ_EN to detect divide-by-zero at issue
// and return quo=8'hFF, rem=dividend, rsp_dz=1 for those operations.
module srt_div_sched #(
  parameter int NREQ    = 4,
  parameter int DIV_LAT = 5,
  parameter int OUT_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [8*NREQ-1:0] req_op1,
  input  logic [8*NREQ-1:0] req_op2,
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [8*NREQ-1:0] rsp_quo,
  output logic [8*NREQ-1:0] rsp_rem,
  output logic [NREQ-1:0]   rsp_dz,
  output logic [7:0]        div_op1_o,
  output logic [7:0]        div_op2_o,
  input  logic [7:0]        div_quo_i,
  input  logic [7:0]        div_rem_i
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = $clog2(OUT_MAX + 1);
  localparam int FP_W  = (OUT_MAX > 1) ? $clog2(OUT_MAX) : 1;

  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(OUT_MAX);
  localparam logic [PTR_W:0]   NREQ_W    = (PTR_W + 1)'(NREQ);
  localparam logic [PTR_W-1:0] LAST_ID   = PTR_W'(NREQ - 1);
  localparam logic [FP_W-1:0]  LAST_SLOT = FP_W'(OUT_MAX - 1);

  // Arbitration state and credits
  logic [PTR_W-1:0] rr_ptr;
  logic [CNT_W-1:0] out_cnt [NREQ];
  logic [NREQ-1:0]  eligible;
  logic [NREQ-1:0]  grant;
  logic             found;
  logic [PTR_W-1:0] grant_id;
  logic [PTR_W:0]   cand;
  logic [7:0]       sel_op1;
  logic [7:0]       sel_op2;

  // Tag pipeline tracking in-flight divider operations
  logic             tag_valid [DIV_LAT];
  logic [PTR_W-1:0] tag_id    [DIV_LAT];
`ifdef SRT_SCHED_DZ_EN
  logic             tag_dz    [DIV_LAT];
  logic [7:0]       tag_op1   [DIV_LAT];
  logic             issue_dz;
`endif

  // Retire path and result FIFOs
  logic [7:0]       ret_quo;
  logic [7:0]       ret_rem;
  logic [NREQ-1:0]  push;
  logic [NREQ-1:0]  pop;
  logic [7:0]       fifo_quo [NREQ][OUT_MAX];
  logic [7:0]       fifo_rem [NREQ][OUT_MAX];
`ifdef SRT_SCHED_DZ_EN
  logic             ret_dz;
  logic             fifo_dz  [NREQ][OUT_MAX];
`endif
  logic [FP_W-1:0]  wr_ptr   [NREQ];
  logic [FP_W-1:0]  rd_ptr   [NREQ];
  logic [CNT_W-1:0] fifo_cnt [NREQ];

  // A requester may compete only while it has credit left; nothing is granted in reset
  always_comb begin
    eligible = '0;
    for (int r = 0; r < NREQ; r++) begin
      eligible[r] = !rst && req_valid[r] && (out_cnt[r] < CNT_MAX);
    end
  end

  // Round-robin search: first eligible requester at or after rr_ptr, wrapping
  always_comb begin
    found    = 1'b0;
    grant_id = '0;
    cand     = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = {1'b0, rr_ptr} + (PTR_W + 1)'(i);
      if (cand >= NREQ_W) cand = cand - NREQ_W;
      if (!found && eligible[cand[PTR_W-1:0]]) begin
        found    = 1'b1;
        grant_id = cand[PTR_W-1:0];
      end
    end
    grant = found ? (NREQ'(1) << grant_id) : '0;
  end

  assign req_ready = grant;

  // Route the granted operands to the divider, substituting a legal divide on divide-by-zero
  always_comb begin
    sel_op1 = '0;
    sel_op2 = '0;
    for (int r = 0; r < NREQ; r++) begin
      if (grant[r]) begin
        sel_op1 = req_op1[8*r +: 8];
        sel_op2 = req_op2[8*r +: 8];
      end
    end
`ifdef SRT_SCHED_DZ_EN
    issue_dz  = found && (sel_op2 == 8'd0);
    div_op1_o = issue_dz ? 8'd0 : sel_op1;
    div_op2_o = issue_dz ? 8'd1 : sel_op2;
`else
    div_op1_o = sel_op1;
    div_op2_o = sel_op2;
`endif
  end

  // Pointer advances past the granted requester and holds when nobody is granted
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (found) begin
      rr_ptr <= (grant_id == LAST_ID) ? '0 : grant_id + PTR_W'(1);
    end
  end

  // Tag valid bits shift alongside the divider; reset drops everything in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DIV_LAT; k++) tag_valid[k] <= 1'b0;
    end else begin
      tag_valid[0] <= found;
      for (int k = 1; k < DIV_LAT; k++) tag_valid[k] <= tag_valid[k-1];
    end
  end

  // Tag payload needs no reset because it is only consumed when its valid bit is set
  always_ff @(posedge clk) begin
    tag_id[0] <= grant_id;
    for (int k = 1; k < DIV_LAT; k++) tag_id[k] <= tag_id[k-1];
`ifdef SRT_SCHED_DZ_EN
    tag_dz[0]  <= issue_dz;
    tag_op1[0] <= sel_op1;
    for (int k = 1; k < DIV_LAT; k++) begin
      tag_dz[k]  <= tag_dz[k-1];
      tag_op1[k] <= tag_op1[k-1];
    end
`endif
  end

  // Retiring result and the FIFO it belongs to
  always_comb begin
`ifdef SRT_SCHED_DZ_EN
    ret_dz  = tag_dz[DIV_LAT-1];
    ret_quo = ret_dz ? 8'hFF : div_quo_i;
    ret_rem = ret_dz ? tag_op1[DIV_LAT-1] : div_rem_i;
`else
    ret_quo = div_quo_i;
    ret_rem = div_rem_i;
`endif
    push = '0;
    for (int r = 0; r < NREQ; r++) begin
      push[r] = tag_valid[DIV_LAT-1] && (tag_id[DIV_LAT-1] == PTR_W'(r));
    end
  end

  assign pop = rsp_valid & rsp_ready;

  // Credits count issued-but-not-popped operations per requester
  always_ff @(posedge clk) begin
    for (int r = 0; r < NREQ; r++) begin
      if (rst) begin
        out_cnt[r] <= '0;
      end else begin
        case ({grant[r], pop[r]})
          2'b10:   out_cnt[r] <= out_cnt[r] + CNT_W'(1);
          2'b01:   out_cnt[r] <= out_cnt[r] - CNT_W'(1);
          default: out_cnt[r] <= out_cnt[r];
        endcase
      end
    end
  end

  // FIFO pointers and occupancy; push and pop together are legal even when full
  always_ff @(posedge clk) begin
    for (int r = 0; r < NREQ; r++) begin
      if (rst) begin
        wr_ptr[r]   <= '0;
        rd_ptr[r]   <= '0;
        fifo_cnt[r] <= '0;
      end else begin
        if (push[r]) wr_ptr[r] <= (wr_ptr[r] == LAST_SLOT) ? '0 : wr_ptr[r] + FP_W'(1);
        if (pop[r])  rd_ptr[r] <= (rd_ptr[r] == LAST_SLOT) ? '0 : rd_ptr[r] + FP_W'(1);
        case ({push[r], pop[r]})
          2'b10:   fifo_cnt[r] <= fifo_cnt[r] + CNT_W'(1);
          2'b01:   fifo_cnt[r] <= fifo_cnt[r] - CNT_W'(1);
          default: fifo_cnt[r] <= fifo_cnt[r];
        endcase
      end
    end
  end

  // FIFO storage; contents are masked at the outputs while a FIFO is empty
  always_ff @(posedge clk) begin
    for (int r = 0; r < NREQ; r++) begin
      if (push[r]) begin
        fifo_quo[r][wr_ptr[r]] <= ret_quo;
        fifo_rem[r][wr_ptr[r]] <= ret_rem;
`ifdef SRT_SCHED_DZ_EN
        fifo_dz[r][wr_ptr[r]]  <= ret_dz;
`endif
      end
    end
  end

  // Head-of-FIFO outputs come straight from registers and ignore rsp_ready
  always_comb begin
    rsp_valid = '0;
    rsp_quo   = '0;
    rsp_rem   = '0;
    rsp_dz    = '0;
    for (int r = 0; r < NREQ; r++) begin
      if (fifo_cnt[r] != '0) begin
        rsp_valid[r]      = 1'b1;
        rsp_quo[8*r +: 8] = fifo_quo[r][rd_ptr[r]];
        rsp_rem[8*r +: 8] = fifo_rem[r][rd_ptr[r]];
`ifdef SRT_SCHED_DZ_EN
        rsp_dz[r]         = fifo_dz[r][rd_ptr[r]];
`endif
      end
    end
  end

`ifndef SYNTHESIS
  logic overflow;

  // A retire into a full FIFO without a matching pop would mean the credit scheme is broken
  always_comb begin
    overflow = 1'b0;
    for (int r = 0; r < NREQ; r++) begin
      if (push[r] && !pop[r] && (fifo_cnt[r] == CNT_MAX)) overflow = 1'b1;
    end
  end

  assert property (@(posedge clk) disable iff (rst) !overflow);
`endif

endmodule

// File: tb/tb_srt_div_sched.sv
// Testbench for srt_div_sched. Provides a behavioural DIV_LAT-stage divider,
// drives requests once per cycle on the falling edge and keeps a per-requester
// scoreboard of expected quotient/remainder/dz triples.
// Honours SRT_SCHED_DZ_EN the same way the design does.
module tb_srt_div_sched;

  localparam int NREQ    = 4;
  localparam int DIV_LAT = 5;
  localparam int OUT_MAX = 4;

`ifdef SRT_SCHED_DZ_EN
  localparam logic DZ_ON = 1'b1;
`else
  localparam logic DZ_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [8*NREQ-1:0] req_op1 = '0;
  logic [8*NREQ-1:0] req_op2 = '0;
  logic [NREQ-1:0]   rsp_valid;
  logic [NREQ-1:0]   rsp_ready = '0;
  logic [8*NREQ-1:0] rsp_quo;
  logic [8*NREQ-1:0] rsp_rem;
  logic [NREQ-1:0]   rsp_dz;
  logic [7:0]        div_op1_o;
  logic [7:0]        div_op2_o;
  logic [7:0]        div_quo_i;
  logic [7:0]        div_rem_i;

  int total = 0;
  int bad   = 0;

  logic [16:0] exp_q [NREQ][$];

  logic [NREQ-1:0]   last_ready;
  logic [NREQ-1:0]   last_valid;
  logic [8*NREQ-1:0] last_quo;
  logic [8*NREQ-1:0] last_rem;
  logic [NREQ-1:0]   last_dz;
  logic [7:0]        last_op1;
  logic [7:0]        last_op2;

  always #5 clk = ~clk;

  srt_div_sched #(.NREQ(NREQ), .DIV_LAT(DIV_LAT), .OUT_MAX(OUT_MAX)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op1   (req_op1),
    .req_op2   (req_op2),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_quo   (rsp_quo),
    .rsp_rem   (rsp_rem),
    .rsp_dz    (rsp_dz),
    .div_op1_o (div_op1_o),
    .div_op2_o (div_op2_o),
    .div_quo_i (div_quo_i),
    .div_rem_i (div_rem_i)
  );

  // Behavioural divider: DIV_LAT registers from operands to outputs, no reset, no stall
  logic [7:0] pipe_quo [DIV_LAT];
  logic [7:0] pipe_rem [DIV_LAT];

  always @(posedge clk) begin
    pipe_quo[0] <= (div_op2_o == 8'd0) ? 8'hFF : div_op1_o / div_op2_o;
    pipe_rem[0] <= (div_op2_o == 8'd0) ? div_op1_o : div_op1_o % div_op2_o;
    for (int k = 1; k < DIV_LAT; k++) begin
      pipe_quo[k] <= pipe_quo[k-1];
      pipe_rem[k] <= pipe_rem[k-1];
    end
  end

  assign div_quo_i = pipe_quo[DIV_LAT-1];
  assign div_rem_i = pipe_rem[DIV_LAT-1];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [16:0] expResult(input logic [7:0] a, input logic [7:0] b);
    if (b == 8'd0) return {8'hFF, a, DZ_ON};
    return {a / b, a % b, 1'b0};
  endfunction

  function automatic logic [8*NREQ-1:0] packOp(input int r, input logic [7:0] val);
    logic [8*NREQ-1:0] v;
    v = '0;
    v[8*r +: 8] = val;
    return v;
  endfunction

  function automatic int pending();
    int n;
    n = 0;
    for (int r = 0; r < NREQ; r++) n += exp_q[r].size();
    return n;
  endfunction

  // One clock cycle: drive inputs, observe grants and pops, then move to the next falling edge
  task automatic applyStimulus(input logic [NREQ-1:0] v, input logic [8*NREQ-1:0] o1,
                               input logic [8*NREQ-1:0] o2, input logic [NREQ-1:0] rr);
    logic [16:0] e;
    req_valid = v;
    req_op1   = o1;
    req_op2   = o2;
    rsp_ready = rr;
    #1;
    last_ready = req_ready;
    last_valid = rsp_valid;
    last_quo   = rsp_quo;
    last_rem   = rsp_rem;
    last_dz    = rsp_dz;
    last_op1   = div_op1_o;
    last_op2   = div_op2_o;
    checkOutput("ready_onehot", 32'($onehot0(req_ready)), 32'd1);
    checkOutput("ready_subset", 32'(req_ready & ~v), 32'd0);
    for (int r = 0; r < NREQ; r++) begin
      if (req_ready[r]) exp_q[r].push_back(expResult(o1[8*r +: 8], o2[8*r +: 8]));
    end
    for (int r = 0; r < NREQ; r++) begin
      if (rsp_valid[r] && rr[r]) begin
        if (exp_q[r].size() == 0) begin
          checkOutput($sformatf("rsp_unexpected_r%0d", r), 32'd1, 32'd0);
        end else begin
          e = exp_q[r].pop_front();
          checkOutput($sformatf("rsp_result_r%0d", r),
                      {15'd0, rsp_quo[8*r +: 8], rsp_rem[8*r +: 8], rsp_dz[r]}, {15'd0, e});
        end
      end
    end
    @(negedge clk);
  endtask

  // Synchronous reset for one cycle with requests pending; scoreboard forgets in-flight work
  task automatic resetDut();
    rst       = 1'b1;
    req_valid = '1;
    req_op1   = '1;
    req_op2   = '1;
    rsp_ready = '0;
    #1;
    checkOutput("rst_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_div_op1", 32'(div_op1_o), 32'd0);
    checkOutput("rst_div_op2", 32'(div_op2_o), 32'd0);
    @(negedge clk);
    rst       = 1'b0;
    req_valid = '0;
    for (int r = 0; r < NREQ; r++) exp_q[r].delete();
    #1;
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_rsp_quo", rsp_quo, 32'd0);
    checkOutput("rst_rsp_rem", rsp_rem, 32'd0);
    checkOutput("rst_rsp_dz", 32'(rsp_dz), 32'd0);
  endtask

  // Pop everything outstanding, bounded by a cycle budget
  task automatic drainAll();
    int budget;
    budget = 0;
    while (pending() != 0 && budget < 200) begin
      applyStimulus('0, '0, '0, '1);
      budget++;
    end
    checkOutput("drain_done", 32'(pending()), 32'd0);
    applyStimulus('0, '0, '0, '1);
    checkOutput("drain_empty", 32'(last_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [8*NREQ-1:0] o1;
    logic [8*NREQ-1:0] o2;
    int wait_cnt;

    @(negedge clk);
    resetDut();

    // Single op: 100/7 from r0, result visible DIV_LAT+1 cycles after acceptance
    applyStimulus(4'b0001, packOp(0, 8'd100), packOp(0, 8'd7), '0);
    checkOutput("single_grant", 32'(last_ready), 32'h1);
    for (int i = 1; i <= DIV_LAT; i++) begin
      applyStimulus('0, '0, '0, '0);
      checkOutput($sformatf("single_early_%0d", i), 32'(last_valid[0]), 32'd0);
    end
    applyStimulus('0, '0, '0, 4'b0001);
    checkOutput("single_valid", 32'(last_valid[0]), 32'd1);
    checkOutput("single_quo", 32'(last_quo[7:0]), 32'd14);
    checkOutput("single_rem", 32'(last_rem[7:0]), 32'd2);
    checkOutput("single_dz", 32'(last_dz[0]), 32'd0);
    applyStimulus('0, '0, '0, '0);
    checkOutput("single_popped", 32'(last_valid[0]), 32'd0);

    // Contention: everyone valid every cycle, popping immediately
    resetDut();
    for (int i = 0; i < 40; i++) begin
      for (int r = 0; r < NREQ; r++) begin
        o1[8*r +: 8] = 8'($urandom_range(0, 255));
        o2[8*r +: 8] = 8'($urandom_range(1, 255));
      end
      applyStimulus('1, o1, o2, '1);
      checkOutput($sformatf("rr_grant_%0d", i), 32'(last_ready), 32'(1 << (i % NREQ)));
    end
    drainAll();

    // Credit stall on r1 with its results held back
    for (int i = 0; i < 10; i++) begin
      applyStimulus(4'b0010, packOp(1, 8'(200 + i)), packOp(1, 8'(3 + i)), '0);
      checkOutput($sformatf("credit_ready_%0d", i), 32'(last_ready[1]), (i < OUT_MAX) ? 32'd1 : 32'd0);
    end
    applyStimulus(4'b0010, packOp(1, 8'd77), packOp(1, 8'd5), 4'b0010);
    checkOutput("credit_pop_cycle", 32'(last_ready[1]), 32'd0);
    checkOutput("credit_pop_valid", 32'(last_valid[1]), 32'd1);
    applyStimulus(4'b0010, packOp(1, 8'd77), packOp(1, 8'd5), '0);
    checkOutput("credit_after_pop", 32'(last_ready[1]), 32'd1);
    applyStimulus(4'b0010, packOp(1, 8'd78), packOp(1, 8'd6), '0);
    checkOutput("credit_refull", 32'(last_ready[1]), 32'd0);
    drainAll();

    // Saturated r2: pop on the cycle the last in-flight op retires
    for (int i = 0; i < 8; i++) begin
      applyStimulus(4'b0100, packOp(2, 8'(17 * i + 9)), packOp(2, 8'(i + 2)), '0);
      checkOutput($sformatf("sat_ready_%0d", i), 32'(last_ready[2]), (i < OUT_MAX) ? 32'd1 : 32'd0);
    end
    applyStimulus(4'b0100, packOp(2, 8'd250), packOp(2, 8'd9), 4'b0100);
    checkOutput("sat_arrival_ready", 32'(last_ready[2]), 32'd0);
    checkOutput("sat_arrival_valid", 32'(last_valid[2]), 32'd1);
    applyStimulus(4'b0100, packOp(2, 8'd250), packOp(2, 8'd9), '0);
    checkOutput("sat_credit_back", 32'(last_ready[2]), 32'd1);
    checkOutput("sat_still_valid", 32'(last_valid[2]), 32'd1);
    applyStimulus(4'b0100, packOp(2, 8'd251), packOp(2, 8'd10), '0);
    checkOutput("sat_refull", 32'(last_ready[2]), 32'd0);
    drainAll();

    // Divide by zero from r3
    applyStimulus(4'b1000, packOp(3, 8'd55), packOp(3, 8'd0), '0);
    checkOutput("dz_grant", 32'(last_ready), 32'h8);
    checkOutput("dz_div_op1", 32'(last_op1), DZ_ON ? 32'd0 : 32'd55);
    checkOutput("dz_div_op2", 32'(last_op2), DZ_ON ? 32'd1 : 32'd0);
    wait_cnt = 0;
    last_valid = '0;
    while (!last_valid[3] && wait_cnt < 20) begin
      applyStimulus('0, '0, '0, '0);
      wait_cnt++;
    end
    checkOutput("dz_seen", 32'(last_valid[3]), 32'd1);
    checkOutput("dz_quo", 32'(last_quo[31:24]), 32'hFF);
    checkOutput("dz_rem", 32'(last_rem[31:24]), 32'd55);
    checkOutput("dz_flag", 32'(last_dz[3]), 32'(DZ_ON));
    drainAll();

    // Mid-operation reset with three ops in flight
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'b0111, {8'd0, 8'd90, 8'd80, 8'd70}, {8'd1, 8'd9, 8'd8, 8'd7}, '0);
      checkOutput($sformatf("midrst_issue_%0d", i), 32'(last_ready != '0), 32'd1);
    end
    resetDut();
    for (int i = 0; i < DIV_LAT + 3; i++) begin
      applyStimulus('0, '0, '0, '1);
      checkOutput($sformatf("midrst_quiet_%0d", i), 32'(last_valid), 32'd0);
    end
    applyStimulus('1, {8'd40, 8'd30, 8'd20, 8'd10}, {8'd4, 8'd3, 8'd2, 8'd1}, '1);
    checkOutput("midrst_rr_zero", 32'(last_ready), 32'h1);
    drainAll();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
